dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory (registered read, 1-cycle latency) between the four multiplier cores.
- Each core issues load/store requests as it executes LDAC, STAC, STTR and similar instructions from instruction memory; the arbiter grants at most one access per cycle.
- It supports short locked bursts for a core's back-to-back accesses and aggregates per-core ENDOP completion into a global done flag.

Parameters:
- DATA_WIDTH, 8, data memory word width.
- ADDR_WIDTH, 8, data memory address width.
- MAX_BURST, 4, maximum consecutive grants to a locked core while any other core is requesting (range 1-15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-core access request, level; held until granted.
- we_in  input  4  per-core write enable (1 = store, 0 = load).
- lock  input  4  per-core burst-lock request; valid only while the same core's req is high.
- addr_in  input  4*ADDR_WIDTH  packed addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_in  input  4*DATA_WIDTH  packed write data, same packing.
- core_done  input  4  per-core ENDOP-reached pulse or level.
- clr_done  input  1  synchronous clear of done flags.
- gnt  output  4  one-hot grant, registered.
- rvalid  output  4  one-hot read-data-valid.
- rdata  output  DATA_WIDTH  read data broadcast to all cores; qualified by rvalid.
- mem_we  output  1  to data memory.
- mem_addr  output  ADDR_WIDTH  to data memory.
- mem_wdata  output  DATA_WIDTH  to data memory.
- mem_rdata  input  DATA_WIDTH  from data memory; valid the cycle after a read is issued.
- all_done  output  1  all four cores finished, sticky.

Behaviour:
- Reset (async, rst_n=0): gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, all_done=0. Done flags = 0, RR pointer = 0 (core 0 highest priority), burst count = 0, state IDLE.
- Eligible set = req & ~done_flag. Requests from finished cores are ignored.
- Cycle N: arbitration on eligible set. Cycle N+1: gnt[w]=1 and mem_we/mem_addr/mem_wdata driven from core w's cycle-N inputs (all registered).
- Read latency: rvalid[w]=1 at N+2; rdata = mem_rdata combinational passthrough, 0 when no rvalid. Writes produce no rvalid.
- Requester sees gnt at N+1 and must drop req or present its next access in cycle N+2. The arbiter therefore never grants the same core in two consecutive cycles unless that core is in LOCKED.
- Round-robin: search order starts at (last winner + 1) mod 4. The pointer advances only on a grant.
- State IDLE: no eligible request -> gnt=0, mem_we=0, hold address. Eligible request -> GRANT.
- State GRANT: winner with lock=1 -> LOCKED, burst count = 1. Otherwise rearbitrate each cycle; no eligible request -> IDLE.
- State LOCKED: owner keeps the grant every cycle while req & lock are held, burst count increments.
  - Owner drops lock or req -> GRANT with normal RR; the owner is excluded from the next cycle's arbitration.
  - Burst count reaches MAX_BURST while another eligible req exists -> forced release: the next winner is the next RR core, not the owner.
  - If no other core requests, the lock persists without limit and the count saturates.
- Only one mem access per cycle; gnt is always one-hot or zero.
- Done: done_flag[i] sets on core_done[i]=1 and stays set.
  - all_done registered = &done_flag, one cycle after the last flag sets.
  - clr_done clears all flags and all_done next cycle; if clr_done and core_done are high in the same cycle, clr_done wins.
- Reset mid-operation: outstanding grants and rvalid are dropped immediately. No memory write occurs after rst_n falls.

Test Plan:
- Single read: core 2 req, we=0, addr=0x08 at cycle 0, mem holds 0x5A -> gnt=4'b0100 at cycle 1, mem_addr=0x08, rvalid=4'b0100 with rdata=0x5A at cycle 2.
- All four request continuously after reset, no lock -> grants cycle core 0,1,2,3,0,... one per cycle; no core granted twice consecutively.
- Core 1 writes 0x33 to 0x09 while core 3 reads 0x09 in the same cycle -> core 1 granted first (mem_we=1), core 3 next cycle; core 3 rvalid returns 0x33.
- Core 0 lock=1 with continuous req, core 2 also requesting, MAX_BURST=4 -> core 0 granted 4 consecutive cycles, then core 2 granted. With core 2 idle, core 0 is held 10+ cycles.
- core_done pulses for cores 0,1,2,3 on cycles 5,7,9,11 -> all_done=1 at cycle 12; later req from core 1 gets no gnt; clr_done=1 -> all_done=0 next cycle.
- rst_n pulled low during a pending read (between gnt and rvalid) -> gnt, rvalid and mem_we drop immediately; after release, core 0 has top priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one single-port data memory
// (registered read, 1-cycle latency) among four multiplier cores.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req/we_in/lock       per-core request, write enable, burst lock (4 bits each)
//   addr_in/wdata_in     packed per-core address / write data (core i at slice i)
//   core_done, clr_done  per-core completion pulses, synchronous clear of done flags
//   gnt, rvalid          one-hot registered grant, one-hot read-data-valid
//   rdata                read data broadcast, zero when no rvalid
//   mem_we/mem_addr/mem_wdata/mem_rdata   data memory interface
//   all_done             sticky, set once every core has reported done
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req,
    input  logic [3:0]              we_in,
    input  logic [3:0]              lock,
    input  logic [4*ADDR_WIDTH-1:0] addr_in,
    input  logic [4*DATA_WIDTH-1:0] wdata_in,
    input  logic [3:0]              core_done,
    input  logic                    clr_done,
    output logic [3:0]              gnt,
    output logic [3:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    all_done
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              gnt_q, gnt_d;
    logic [3:0]              rvalid_q;
    logic [3:0]              done_q, done_d;
    logic                    all_done_q;
    logic [1:0]              ptr_q, ptr_d;   // highest-priority core for next search
    logic [3:0]              cnt_q, cnt_d;   // burst length of current lock owner
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic [3:0] elig;
    logic [3:0] cand;
    logic       others;
    logic       keep;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] rr_idx;

    assign elig   = req & ~done_q;
    assign others = |(elig & ~gnt_q);
    // Lock owner is the core currently holding gnt; it keeps the memory unless
    // it lets go or has used up its burst while someone else is waiting.
    assign keep   = (state_q == StLocked) && (|(gnt_q & elig & lock)) &&
                    !((cnt_q >= MaxBurst) && others);

    // Round-robin pick. The currently granted core is excluded: its req is
    // still up for the access it is being granted right now.
    always_comb begin
        cand    = keep ? 4'b0000 : (elig & ~gnt_q);
        win_vld = 1'b0;
        win_idx = ptr_q;
        rr_idx  = ptr_q;
        // Walk from farthest to nearest so the nearest candidate wins.
        for (int k = 3; k >= 0; k--) begin
            rr_idx = ptr_q + 2'(k);
            if (cand[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
        if (keep) begin
            win_vld = 1'b1;
            win_idx = ptr_q - 2'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (keep) begin
            state_d = StLocked;
            if (cnt_q < MaxBurst) cnt_d = cnt_q + 4'd1;
        end else if (win_vld) begin
            ptr_d = win_idx + 2'd1;
            if (lock[win_idx]) begin
                state_d = StLocked;
                cnt_d   = 4'd1;
            end else begin
                state_d = StGrant;
                cnt_d   = 4'd0;
            end
        end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end
    end

    // Output logic (registered memory command)
    always_comb begin
        gnt_d       = 4'b0000;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (win_vld) begin
            gnt_d       = 4'b0001 << win_idx;
            mem_we_d    = we_in[win_idx];
            mem_addr_d  = addr_in[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_d = wdata_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // clr_done has priority over a coincident core_done.
    assign done_d = clr_done ? 4'b0000 : (done_q | core_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= 4'b0000;
            rvalid_q    <= 4'b0000;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 4'b0000;
            all_done_q  <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= gnt_q & {4{~mem_we_q}};
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            all_done_q  <= &done_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = (|rvalid_q) ? mem_rdata : '0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign all_done  = all_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_dmem_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = '0, we_in = '0, lock = '0, core_done = '0;
    logic          clr_done = 1'b0;
    logic [AW-1:0] a [4];
    logic [DW-1:0] wd [4];
    logic [4*AW-1:0] addr_in;
    logic [4*DW-1:0] wdata_in;
    logic [3:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_we, all_done;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    int         m_gnt, m_rv, m_prio, m_burst;
    bit         m_locked, m_we, m_all;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    bit [3:0]   m_done;

    assign addr_in  = {a[3], a[2], a[1], a[0]};
    assign wdata_in = {wd[3], wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we_in(we_in), .lock(lock),
        .addr_in(addr_in), .wdata_in(wdata_in), .core_done(core_done),
        .clr_done(clr_done), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .all_done(all_done)
    );

    // Data memory: registered read, write on clock edge
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_rv = -1; m_prio = 0; m_burst = 0; m_locked = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_done = '0; m_all = 0;
    endtask

    // One clock of the reference behaviour, from the inputs seen at the edge.
    task automatic model_step();
        int win;
        int nrv;
        bit others;
        bit [3:0] e;
        logic [DW-1:0] nrd;
        nrv = (m_gnt >= 0 && !m_we) ? m_gnt : -1;
        nrd = ref_mem[m_addr];
        if (m_gnt >= 0 && m_we) ref_mem[m_addr] = m_wdata;
        for (int i = 0; i < 4; i++) e[i] = req[i] && !m_done[i];
        others = 0;
        for (int i = 0; i < 4; i++) if (e[i] && i != m_gnt) others = 1;
        win = -1;
        if (m_locked && m_gnt >= 0 && e[m_gnt] && lock[m_gnt] && !(m_burst >= MB && others)) begin
            win = m_gnt;
            if (m_burst < MB) m_burst++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_prio + k) % 4;
                if (win < 0 && e[i] && i != m_gnt) win = i;
            end
            if (win >= 0) begin
                m_locked = lock[win];
                m_burst  = lock[win] ? 1 : 0;
                m_prio   = (win + 1) % 4;
            end else begin
                m_locked = 0;
                m_burst  = 0;
            end
        end
        if (win >= 0) begin
            m_we = we_in[win]; m_addr = a[win]; m_wdata = wd[win];
        end else begin
            m_we = 0;
        end
        if (clr_done) m_done = '0;
        else m_done |= core_done;
        m_all = &m_done;
        m_gnt = win; m_rv = nrv; m_rdata = nrd;
    endtask

    task automatic compare(input string ctx);
        check({ctx, ":gnt"}, 32'(gnt), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
        check({ctx, ":mem_we"}, 32'(mem_we), 32'(m_we));
        check({ctx, ":mem_addr"}, 32'(mem_addr), 32'(m_addr));
        check({ctx, ":mem_wdata"}, 32'(mem_wdata), 32'(m_wdata));
        check({ctx, ":rvalid"}, 32'(rvalid), (m_rv >= 0) ? (32'd1 << m_rv) : 32'd0);
        check({ctx, ":rdata"}, 32'(rdata), (m_rv >= 0) ? 32'(m_rdata) : 32'd0);
        check({ctx, ":all_done"}, 32'(all_done), 32'(m_all));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_step();
        #1;
        compare(ctx);
    endtask

    task automatic clear_inputs();
        req = '0; we_in = '0; lock = '0; core_done = '0; clr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin a[i] = '0; wd[i] = '0; end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        compare("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[8] = 8'h5A;
        ref_mem[8] = 8'h5A;
        mem_rdata = '0;
        clear_inputs();
        model_reset();

        // Single read by core 2
        do_reset();
        req = 4'b0100; a[2] = 8'h08;
        step("rd1");
        check("rd1_gnt", 32'(gnt), 32'h4);
        check("rd1_addr", 32'(mem_addr), 32'h08);
        step("rd2");
        req = '0;
        check("rd2_rvalid", 32'(rvalid), 32'h4);
        check("rd2_rdata", 32'(rdata), 32'h5A);
        step("rd3");

        // All four request continuously, no lock
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step("rr");
            check("rr_order", 32'(gnt), 32'd1 << (c % 4));
        end

        // Core 1 writes 0x33 to 0x09 while core 3 reads 0x09
        do_reset();
        req = 4'b1010; we_in = 4'b0010; a[1] = 8'h09; wd[1] = 8'h33; a[3] = 8'h09;
        step("wr1");
        check("wr1_gnt", 32'(gnt), 32'h2);
        check("wr1_we", 32'(mem_we), 32'h1);
        step("wr2");
        check("wr2_gnt", 32'(gnt), 32'h8);
        req = '0; we_in = '0;
        step("wr3");
        check("wr3_rvalid", 32'(rvalid), 32'h8);
        check("wr3_rdata", 32'(rdata), 32'h33);

        // Locked burst: core 0 vs core 2, then core 0 alone
        do_reset();
        req = 4'b0101; lock = 4'b0001;
        for (int c = 0; c < MB; c++) begin
            step("lk");
            check("lk_owner", 32'(gnt), 32'h1);
        end
        step("lk_rel");
        check("lk_release", 32'(gnt), 32'h4);
        do_reset();
        req = 4'b0001; lock = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            step("lk_solo");
            check("lk_solo_owner", 32'(gnt), 32'h1);
        end

        // Done aggregation, done-core masking, clear
        do_reset();
        for (int c = 0; c < 12; c++) begin
            core_done = (c == 5) ? 4'b0001 : (c == 7) ? 4'b0010 :
                        (c == 9) ? 4'b0100 : (c == 11) ? 4'b1000 : 4'b0000;
            if (c == 11) check("done_pre", 32'(all_done), 32'h0);
            step("done");
        end
        core_done = '0;
        check("done_all", 32'(all_done), 32'h1);
        req = 4'b0010;
        step("done_mask");
        step("done_mask");
        check("done_nognt", 32'(gnt), 32'h0);
        req = '0; clr_done = 1'b1;
        step("done_clr");
        clr_done = 1'b0;
        check("done_cleared", 32'(all_done), 32'h0);

        // Reset during a pending read
        do_reset();
        req = 4'b0001; a[0] = 8'h10;
        step("mid");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_gnt", 32'(gnt), 32'h0);
        check("mid_rvalid", 32'(rvalid), 32'h0);
        check("mid_we", 32'(mem_we), 32'h0);
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        step("mid_after");
        check("mid_prio", 32'(gnt), 32'h1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                req[i]       = ($urandom_range(0, 9) < 7);
                we_in[i]     = $urandom_range(0, 1);
                lock[i]      = ($urandom_range(0, 9) < 5);
                core_done[i] = ($urandom_range(0, 99) < 2);
                a[i]         = 8'($urandom_range(0, 255));
                wd[i]        = 8'($urandom_range(0, 255));
            end
            clr_done = ($urandom_range(0, 99) < 5);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
